// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU operand loader and the ALU operation units.
package alu_pkg;

   localparam int unsigned M_DEF          = 4;
   localparam int unsigned N_DEF          = 3;
   localparam int unsigned DEB_CICLOS_DEF = 16;

   typedef enum logic [1:0] {
      ESPERA_A  = 2'd0,
      ESPERA_B  = 2'd1,
      ESPERA_OP = 2'd2,
      LISTO     = 2'd3
   } estado_t;

   localparam logic [N_DEF-1:0] OP_AND   = 3'd0;
   localparam logic [N_DEF-1:0] OP_OR    = 3'd1;
   localparam logic [N_DEF-1:0] OP_XOR   = 3'd2;
   localparam logic [N_DEF-1:0] OP_SUMA  = 3'd3;
   localparam logic [N_DEF-1:0] OP_RESTA = 3'd4;

endpackage

// File: rtl/detector_flanco.sv
// Synchronizes a raw button and emits one registered pulse per press.
// Optional debounce filter enabled with ALU_DEBOUNCE_EN.
module detector_flanco
`ifdef ALU_DEBOUNCE_EN
#(
   parameter int unsigned DEB_CICLOS = alu_pkg::DEB_CICLOS_DEF
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic entrada_cruda,
   output logic pulso
);

   logic sync1_q;
   logic sync2_q;
   logic nivel;
   logic nivel_prev_q;
   logic pulso_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         nivel_prev_q <= 1'b0;
         pulso_q      <= 1'b0;
      end else begin
         sync1_q      <= entrada_cruda;
         sync2_q      <= sync1_q;
         nivel_prev_q <= nivel;
         pulso_q      <= nivel & ~nivel_prev_q;
      end
   end

`ifdef ALU_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEB_CICLOS + 1);

   logic          nivel_q;
   logic [CW-1:0] cnt_q;

   // Filtered level only follows sync2 after DEB_CICLOS stable cycles; any bounce restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         nivel_q <= 1'b0;
         cnt_q   <= '0;
      end else if (sync2_q == nivel_q) begin
         cnt_q   <= '0;
      end else if (cnt_q == CW'(DEB_CICLOS - 1)) begin
         nivel_q <= sync2_q;
         cnt_q   <= '0;
      end else begin
         cnt_q   <= cnt_q + CW'(1);
      end
   end

   assign nivel = nivel_q;
`else
   assign nivel = sync2_q;
`endif

   assign pulso = pulso_q;

endmodule

// File: rtl/alu_cargador_operandos.sv
// Loads operand A, operand B and opcode from a shared switch bus, one per button press,
// then holds them for the ALU under a valid/ack handshake. Debounce enabled with ALU_DEBOUNCE_EN.
module alu_cargador_operandos
   import alu_pkg::*;
#(
   parameter int unsigned M = M_DEF,
   parameter int unsigned N = N_DEF
`ifdef ALU_DEBOUNCE_EN
   ,
   parameter int unsigned DEB_CICLOS = DEB_CICLOS_DEF
`endif
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [M-1:0] entrada,
   input  logic         boton_carga,
   input  logic         boton_cancelar,
   input  logic         alu_ack,
   output logic [M-1:0] expresionA,
   output logic [M-1:0] expresionB,
   output logic [N-1:0] operacion,
   output logic         valido,
   output logic [1:0]   estado
);

   logic pulso;

`ifdef ALU_DEBOUNCE_EN
   detector_flanco #(.DEB_CICLOS(DEB_CICLOS)) u_det_carga (
`else
   detector_flanco u_det_carga (
`endif
      .clk           (clk),
      .rst           (rst),
      .entrada_cruda (boton_carga),
      .pulso         (pulso)
   );

   estado_t        state_q, state_d;
   logic [M-1:0]   a_q, a_d;
   logic [M-1:0]   b_q, b_d;
   logic [N-1:0]   op_q, op_d;
   logic           valido_q, valido_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ESPERA_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         valido_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         valido_q <= valido_d;
      end
   end

   // Load sequence A -> B -> opcode -> hold until ack; cancel overrides pulse and ack.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      valido_d = valido_q;
      case (state_q)
         ESPERA_A: begin
            if (pulso) begin
               a_d     = entrada;
               state_d = ESPERA_B;
            end
         end
         ESPERA_B: begin
            if (pulso) begin
               b_d     = entrada;
               state_d = ESPERA_OP;
            end
         end
         ESPERA_OP: begin
            if (pulso) begin
               op_d     = entrada[N-1:0];
               valido_d = 1'b1;
               state_d  = LISTO;
            end
         end
         LISTO: begin
            if (alu_ack) begin
               valido_d = 1'b0;
               state_d  = ESPERA_A;
            end
         end
         default: state_d = ESPERA_A;
      endcase
      if (boton_cancelar) begin
         state_d  = ESPERA_A;
         a_d      = '0;
         b_d      = '0;
         op_d     = '0;
         valido_d = 1'b0;
      end
   end

   assign expresionA = a_q;
   assign expresionB = b_q;
   assign operacion  = op_q;
   assign valido     = valido_q;
   assign estado     = 2'(state_q);

endmodule

// File: tb/tb_alu_cargador_operandos.sv
// Bench for alu_cargador_operandos: cycle model of the load/handshake rules plus directed literal checks.
module tb_alu_cargador_operandos;

   localparam int unsigned M = 4;
   localparam int unsigned N = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [M-1:0] entrada = '0;
   logic         boton_carga = 1'b0;
   logic         boton_cancelar = 1'b0;
   logic         alu_ack = 1'b0;
   logic [M-1:0] expresionA;
   logic [M-1:0] expresionB;
   logic [N-1:0] operacion;
   logic         valido;
   logic [1:0]   estado;

   alu_cargador_operandos dut (
      .clk            (clk),
      .rst            (rst),
      .entrada        (entrada),
      .boton_carga    (boton_carga),
      .boton_cancelar (boton_cancelar),
      .alu_ack        (alu_ack),
      .expresionA     (expresionA),
      .expresionB     (expresionB),
      .operacion      (operacion),
      .valido         (valido),
      .estado         (estado)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
   endtask

   // Model: the raw button sampled at edge j becomes a load at edge j+3 if it was low at j-1.
   bit           hist [0:8191];
   int           cyc = 0;
   int           ult_rst = -1;
   int           fase = 0;
   logic [M-1:0] eA = '0;
   logic [M-1:0] eB = '0;
   logic [N-1:0] eOp = '0;
   logic         eV = 1'b0;
   bit           arrancado = 1'b0;

   function automatic bit muestra(input int j);
      if (j < 0 || j <= ult_rst) return 1'b0;
      return hist[j];
   endfunction

   always @(posedge clk) begin
      bit p;
      hist[cyc] = boton_carga;
      if (rst) ult_rst = cyc;
      p = muestra(cyc - 3) && !muestra(cyc - 4);
      if (rst || boton_cancelar) begin
         fase = 0; eA = '0; eB = '0; eOp = '0; eV = 1'b0;
      end else begin
         case (fase)
            0: if (p) begin eA = entrada; fase = 1; end
            1: if (p) begin eB = entrada; fase = 2; end
            2: if (p) begin eOp = entrada[N-1:0]; eV = 1'b1; fase = 3; end
            default: if (alu_ack) begin eV = 1'b0; fase = 0; end
         endcase
      end
      if (rst) arrancado = 1'b1;
      cyc++;
   end

   always @(negedge clk) begin
      if (arrancado) begin
         chk("model_A",      32'(expresionA), 32'(eA));
         chk("model_B",      32'(expresionB), 32'(eB));
         chk("model_op",     32'(operacion),  32'(eOp));
         chk("model_valido", 32'(valido),     32'(eV));
         chk("model_estado", 32'(estado),     32'(fase));
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulsar(input logic [M-1:0] v, input int hold);
      @(negedge clk);
      entrada     = v;
      boton_carga = 1'b1;
      repeat (hold) @(negedge clk);
      boton_carga = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      ciclos(3);
      rst = 1'b0;
      ciclos(2);
      chk("rst_A",      32'(expresionA), 32'h0);
      chk("rst_B",      32'(expresionB), 32'h0);
      chk("rst_op",     32'(operacion),  32'h0);
      chk("rst_valido", 32'(valido),     32'h0);
      chk("rst_estado", 32'(estado),     32'h0);

      // First press with explicit capture-edge timing
      @(negedge clk); entrada = 4'hA; boton_carga = 1'b1;
      @(negedge clk);
      @(negedge clk); boton_carga = 1'b0;
      @(negedge clk); chk("lat_k2_estado", 32'(estado), 32'h0);
      @(negedge clk); chk("lat_k3_estado", 32'(estado), 32'h1);
      chk("lat_k3_A", 32'(expresionA), 32'hA);
      ciclos(4);
      pulsar(4'h5, 2);
      pulsar(4'h2, 2);
      chk("full_A",      32'(expresionA), 32'hA);
      chk("full_B",      32'(expresionB), 32'h5);
      chk("full_op",     32'(operacion),  32'h2);
      chk("full_valido", 32'(valido),     32'h1);
      chk("full_estado", 32'(estado),     32'h3);

      // Press while LISTO is ignored
      pulsar(4'hF, 2);
      chk("listo_A",      32'(expresionA), 32'hA);
      chk("listo_op",     32'(operacion),  32'h2);
      chk("listo_estado", 32'(estado),     32'h3);

      @(negedge clk); alu_ack = 1'b1;
      @(negedge clk); alu_ack = 1'b0;
      chk("ack_valido", 32'(valido),     32'h0);
      chk("ack_estado", 32'(estado),     32'h0);
      chk("ack_A_kept", 32'(expresionA), 32'hA);
      chk("ack_B_kept", 32'(expresionB), 32'h5);

      // Held button gives a single load
      pulsar(4'h7, 50);
      chk("held_A",      32'(expresionA), 32'h7);
      chk("held_estado", 32'(estado),     32'h1);

      // Cancel on the same edge as the B capture pulse
      @(negedge clk); entrada = 4'h9; boton_carga = 1'b1;
      @(negedge clk);
      @(negedge clk); boton_carga = 1'b0;
      @(negedge clk); boton_cancelar = 1'b1;
      @(negedge clk); boton_cancelar = 1'b0;
      chk("cancel_A",      32'(expresionA), 32'h0);
      chk("cancel_B",      32'(expresionB), 32'h0);
      chk("cancel_valido", 32'(valido),     32'h0);
      chk("cancel_estado", 32'(estado),     32'h0);
      ciclos(4);

      // Reset during ESPERA_OP
      pulsar(4'h3, 2);
      pulsar(4'hC, 2);
      chk("pre_rst_estado", 32'(estado),     32'h2);
      chk("pre_rst_B",      32'(expresionB), 32'hC);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midrst_A",      32'(expresionA), 32'h0);
      chk("midrst_B",      32'(expresionB), 32'h0);
      chk("midrst_estado", 32'(estado),     32'h0);
      @(negedge clk); alu_ack = 1'b1;
      @(negedge clk); alu_ack = 1'b0;
      chk("ack_idle_estado", 32'(estado), 32'h0);
      chk("ack_idle_valido", 32'(valido), 32'h0);
      ciclos(4);

      // Ack outside LISTO has no effect
      pulsar(4'h1, 2);
      @(negedge clk); alu_ack = 1'b1;
      @(negedge clk); alu_ack = 1'b0;
      chk("ack_b_estado", 32'(estado),     32'h1);
      chk("ack_b_A",      32'(expresionA), 32'h1);

      // Opcode uses only the low N bits of the bus
      pulsar(4'h6, 2);
      pulsar(4'hE, 2);
      chk("trunc_B",      32'(expresionB), 32'h6);
      chk("trunc_op",     32'(operacion),  32'h6);
      chk("trunc_valido", 32'(valido),     32'h1);
      chk("trunc_estado", 32'(estado),     32'h3);

      // Cancel beats a simultaneous ack in LISTO
      @(negedge clk); alu_ack = 1'b1; boton_cancelar = 1'b1;
      @(negedge clk); alu_ack = 1'b0; boton_cancelar = 1'b0;
      chk("cancel_ack_A",      32'(expresionA), 32'h0);
      chk("cancel_ack_op",     32'(operacion),  32'h0);
      chk("cancel_ack_estado", 32'(estado),     32'h0);
      ciclos(3);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
